// File: rtl/seq_signed_divider.sv
// Sequential signed restoring divider: one quotient bit per clock, fixed N+1 clock latency.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module seq_signed_divider #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned RW = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         r_state, w_state;
  logic [CW-1:0]  r_count, w_count;
  logic [RW-1:0]  r_rem, w_rem;
  logic [N-1:0]   r_qd, w_qd;
  logic [N-1:0]   r_dvs, w_dvs;
  logic [N-1:0]   r_raw, w_raw;
  logic           r_sign_q, w_sign_q;
  logic           r_sign_r, w_sign_r;
  logic           r_dz, w_dz;
  logic           r_busy, w_busy;
  logic           r_done, w_done;
  logic [N-1:0]   r_quot, w_quot;
  logic [N-1:0]   r_remo, w_remo;
  logic           r_dbz, w_dbz;

  // One restoring step: shift in the next dividend bit, trial-subtract with borrow out.
  logic [RW-1:0]  w_shift;
  logic [RW-1:0]  w_trial;
  logic           w_borrow;
  logic [N-1:0]   w_dvd_mag;
  logic [N-1:0]   w_dvs_mag;
  logic [N-1:0]   w_rmag;

  assign w_shift               = (r_rem << 1) | RW'(r_qd[N-1]);
  assign {w_borrow, w_trial}   = {1'b0, w_shift} - (RW + 1)'(r_dvs);
  assign w_dvd_mag             = i_dividend[N-1] ? N'(-i_dividend) : i_dividend;
  assign w_dvs_mag             = i_divisor[N-1]  ? N'(-i_divisor)  : i_divisor;
  assign w_rmag                = r_rem[N-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rem    <= '0;
      r_qd     <= '0;
      r_dvs    <= '0;
      r_raw    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_remo   <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_rem    <= w_rem;
      r_qd     <= w_qd;
      r_dvs    <= w_dvs;
      r_raw    <= w_raw;
      r_sign_q <= w_sign_q;
      r_sign_r <= w_sign_r;
      r_dz     <= w_dz;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_quot   <= w_quot;
      r_remo   <= w_remo;
      r_dbz    <= w_dbz;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_rem    = r_rem;
    w_qd     = r_qd;
    w_dvs    = r_dvs;
    w_raw    = r_raw;
    w_sign_q = r_sign_q;
    w_sign_r = r_sign_r;
    w_dz     = r_dz;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_quot   = r_quot;
    w_remo   = r_remo;
    w_dbz    = r_dbz;

    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_qd     = w_dvd_mag;
          w_dvs    = w_dvs_mag;
          w_raw    = i_dividend;
          w_sign_q = i_dividend[N-1] ^ i_divisor[N-1];
          w_sign_r = i_dividend[N-1];
          w_dz     = (i_divisor == '0);
          w_rem    = '0;
          w_count  = '0;
          w_busy   = 1'b1;
          w_state  = CALC;
        end
      end
      CALC: begin
        w_rem   = w_borrow ? w_shift : w_trial;
        w_qd    = {r_qd[N-2:0], ~w_borrow};
        w_count = r_count + CW'(1);
        if (r_count == CW'(N - 1)) begin
          w_state = FIX;
        end
      end
      FIX: begin
        // Divide-by-zero overrides the arithmetic result with the defined fallback.
        if (r_dz) begin
          w_quot = '1;
          w_remo = r_raw;
        end else begin
          w_quot = r_sign_q ? N'(-r_qd)   : r_qd;
          w_remo = r_sign_r ? N'(-w_rmag) : w_rmag;
        end
        w_dbz   = r_dz;
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_remo;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (N=8): results, latency, handshake, divide-by-zero, reset abort.
module tb_seq_signed_divider;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic [7:0] i_dividend;
  logic [7:0] i_divisor;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_quotient;
  logic [7:0] o_remainder;
  logic       o_div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_signed_divider #(.N(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_dividend    (i_dividend),
    .i_divisor     (i_divisor),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_quotient    (o_quotient),
    .o_remainder   (o_remainder),
    .o_div_by_zero (o_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the divider idle; returns #1 after the edge following done.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int lat;
    int nbusy;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (!o_done && lat < 30) begin
      if (o_busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 9);
    chk({tag, " busy_cycles"}, nbusy, 9);
    chk({tag, " quotient"}, o_quotient, eq);
    chk({tag, " remainder"}, o_remainder, er);
    chk({tag, " div_by_zero"}, o_div_by_zero, edz);
    chk({tag, " busy_at_done"}, o_busy, 0);
    @(posedge clk); #1;
    chk({tag, " done_single"}, o_done, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    int stable;

    reset      = 1'b1;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset quotient", o_quotient, 0);
    chk("reset remainder", o_remainder, 0);
    chk("reset dz", o_div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("100/7",    8'd100,  8'd7,   8'd14,   8'd2,    1'b0);
    run_op("-100/7",   8'h9C,   8'd7,   8'hF2,   8'hFE,   1'b0);
    run_op("100/-7",   8'd100,  8'hF9,  8'hF2,   8'd2,    1'b0);
    run_op("-100/-7",  8'h9C,   8'hF9,  8'd14,   8'hFE,   1'b0);
    run_op("3/10",     8'd3,    8'd10,  8'd0,    8'd3,    1'b0);
    run_op("-7/7",     8'hF9,   8'd7,   8'hFF,   8'd0,    1'b0);
    run_op("5/0",      8'd5,    8'd0,   8'hFF,   8'd5,    1'b1);
    run_op("20/4",     8'd20,   8'd4,   8'd5,    8'd0,    1'b0);
    run_op("-128/-1",  8'h80,   8'hFF,  8'h80,   8'd0,    1'b0);
    run_op("-128/1",   8'h80,   8'd1,   8'h80,   8'd0,    1'b0);
    run_op("127/-128", 8'd127,  8'h80,  8'd0,    8'd127,  1'b0);

    // Start pulses while busy must be ignored and not queued.
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    ndone = 0;
    for (int k = 1; k <= 24; k++) begin
      i_start    = (k == 3 || k == 5);
      i_dividend = (k == 3 || k == 5) ? 8'd1 : 8'd100;
      i_divisor  = (k == 3 || k == 5) ? 8'd1 : 8'd7;
      @(posedge clk); #1;
      i_start = 1'b0;
      if (o_done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    chk("ignore done_count", ndone, 1);
    chk("ignore latency", lat, 9);
    chk("ignore quotient", o_quotient, 8'd14);
    chk("ignore remainder", o_remainder, 8'd2);
    chk("ignore busy", o_busy, 0);

    // Start held through the done cycle launches the next operation.
    i_dividend = 8'd20;
    i_divisor  = 8'd4;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b first_quotient", o_quotient, 8'd5);
    i_dividend = 8'h9C;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("b2b accepted_busy", o_busy, 1);
    lat = 0;
    stable = 1;
    while (!o_done && lat < 30) begin
      if (o_quotient !== 8'd5 || o_remainder !== 8'd0) stable = 0;
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b old_result_held", stable, 1);
    chk("b2b latency", lat, 9);
    chk("b2b quotient", o_quotient, 8'hF2);
    chk("b2b remainder", o_remainder, 8'hFE);
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done pulse.
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort busy", o_busy, 0);
    chk("abort done", o_done, 0);
    chk("abort quotient", o_quotient, 0);
    chk("abort remainder", o_remainder, 0);
    chk("abort dz", o_div_by_zero, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (o_done || o_busy) ndone++;
    end
    chk("abort no_activity", ndone, 0);

    run_op("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
